sfi5_rx_lane_checker: RTL and testbench
=======================================

Name: sfi5_rx_lane_checker

Overview:
- Per-lane receive data checker that consumes one 16-bit system-side RX lane output (ov_RXDATAnn_OUT) of the SFI-5 interface in the RX user clock domain.
- Checks the incrementing-word pattern that the TX-side pattern source injects.
- Reports lock status, counts mismatches, keeps a sticky loss-of-lock flag, and counts checked words.
- One instance per data lane. Top-level diagnostics aggregate the instances.

Parameters:
DATA_WIDTH, 16, lane word width in bits
INCR, 1, expected difference between consecutive valid words, modulo 2^DATA_WIDTH
CNT_WIDTH, 16, width of the mismatch counter and the words-checked counter

Ports:
i_CLK  in  1  RX user clock (o_RXUSRCLK2 domain)
i_RST  in  1  synchronous, active-high reset
i_VALID  in  1  iv_DATA holds a lane word this cycle
iv_DATA  in  DATA_WIDTH  received lane word
i_CLEAR  in  1  synchronous clear of counters and history; level-sensitive
iv_GOOD2LOCK  in  7  consecutive good words required to lock; 0 is treated as 1
iv_BAD2UNLOCK  in  7  consecutive bad words in LOCKED that force unlock; 0 is treated as 1
o_LOCKED  out  1  checker is in LOCKED state
o_ERROR  out  1  one-cycle pulse per mismatching word while LOCKED
o_LOSS_HISTORY  out  1  sticky: set on every LOCKED->HUNT transition
ov_MISMATCHES  out  CNT_WIDTH  mismatches counted while LOCKED; saturates at all-ones
ov_WORDS_CHECKED  out  CNT_WIDTH  valid words compared while LOCKED; saturates at all-ones

Behaviour:
- Reset (i_RST=1 at a clock edge):
  - state=HUNT; all outputs 0; internal prev word, expected word, good count and bad count all 0.
  - Reset mid-operation aborts any lock immediately.
  - Reset does not set o_LOSS_HISTORY.
- i_VALID=0: state, counters and the prediction register hold; o_ERROR=0.
- All outputs are registered and update on the edge that samples the valid word (1-cycle latency).
- Width rule: all word arithmetic is modulo 2^DATA_WIDTH. The prediction for 16'hFFFF with INCR=1 is 16'h0000.
- HUNT state, per valid word:
  - Good word: iv_DATA == prev+INCR. good_cnt increments, saturating at 127.
  - Any other word: good_cnt=0.
  - prev <= iv_DATA on every valid word (re-seed).
  - The first valid word after reset or after unlock only seeds prev and counts as neither good nor bad.
  - When the updated good_cnt >= max(iv_GOOD2LOCK,1): go to LOCKED; exp <= iv_DATA+INCR; bad_cnt=0.
- LOCKED state, per valid word:
  - ov_WORDS_CHECKED increments.
  - Match (iv_DATA == exp): bad_cnt=0.
  - Mismatch: o_ERROR=1 for one cycle, ov_MISMATCHES increments, bad_cnt increments.
  - exp <= exp+INCR in both cases (flywheel). A single corrupted word therefore costs exactly one mismatch.
  - When the updated bad_cnt >= max(iv_BAD2UNLOCK,1): go to HUNT; o_LOSS_HISTORY=1; good_cnt=0; prev <= iv_DATA (this word seeds the hunt).
- i_CLEAR=1:
  - ov_MISMATCHES, ov_WORDS_CHECKED and o_LOSS_HISTORY go to 0 on that edge.
  - Clear has priority over a same-cycle increment or loss event; that event is dropped.
  - Clear does not affect state, o_LOCKED or the prediction.
- Threshold ports are sampled every cycle. Changing them while LOCKED affects only subsequent comparisons.
- Counter saturation: at all-ones the counter holds; it never wraps to 0.

Test Plan:
- Reset, GOOD2LOCK=2: feed valid 0x0010, 0x0011, 0x0012 -> o_LOCKED=1 one cycle after 0x0012; ov_MISMATCHES=0, o_ERROR never asserted.
- Locked, BAD2UNLOCK=2: stream 0x0013, 0x9999, 0x0015 -> single o_ERROR pulse after 0x9999; ov_MISMATCHES=1; ov_WORDS_CHECKED=3; o_LOCKED stays 1.
- Locked, BAD2UNLOCK=2: two consecutive bad words -> ov_MISMATCHES=2, o_LOCKED=0, o_LOSS_HISTORY=1. Restart at 0x0100, 0x0101, 0x0102 -> relock with o_LOSS_HISTORY still 1.
- Wrap: lock on 0xFFFE, 0xFFFF, then feed 0x0000, 0x0001 -> no errors; i_VALID gaps of 3 cycles mid-stream -> no errors, counters frozen during the gaps.
- i_CLEAR asserted in the same cycle as a mismatch -> ov_MISMATCHES=0, o_LOSS_HISTORY=0, o_ERROR still pulses, o_LOCKED unchanged.
- CNT_WIDTH=4: 20 locked mismatches with BAD2UNLOCK=127 -> ov_MISMATCHES=0xF (saturated). Assert i_RST mid-stream -> all outputs 0 next cycle, state HUNT.

Source files
------------

// File: rtl/sfi5_rx_lane_checker_if.sv
// Lane-side bundle of one SFI-5 RX pattern checker: the received word stream,
// the lock thresholds and the diagnostic outputs.
interface sfi5_rx_lane_checker_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
);
   logic                  i_VALID;
   logic [DATA_WIDTH-1:0] iv_DATA;
   logic                  i_CLEAR;
   logic [6:0]            iv_GOOD2LOCK;
   logic [6:0]            iv_BAD2UNLOCK;
   logic                  o_LOCKED;
   logic                  o_ERROR;
   logic                  o_LOSS_HISTORY;
   logic [CNT_WIDTH-1:0]  ov_MISMATCHES;
   logic [CNT_WIDTH-1:0]  ov_WORDS_CHECKED;

   modport master (
      output i_VALID, iv_DATA, i_CLEAR, iv_GOOD2LOCK, iv_BAD2UNLOCK,
      input  o_LOCKED, o_ERROR, o_LOSS_HISTORY, ov_MISMATCHES, ov_WORDS_CHECKED
   );

   modport slave (
      input  i_VALID, iv_DATA, i_CLEAR, iv_GOOD2LOCK, iv_BAD2UNLOCK,
      output o_LOCKED, o_ERROR, o_LOSS_HISTORY, ov_MISMATCHES, ov_WORDS_CHECKED
   );
endinterface

// File: rtl/sfi5_rx_lane_checker.sv
// Per-lane checker for the incrementing-word pattern on one SFI-5 RX lane.
// Hunts for a run of consecutive words, then flywheels the prediction while locked.
//
// state  | meaning
// HUNT   | re-seeding from every valid word, counting consecutive good words
// LOCKED | comparing against a free-running prediction, counting errors
module sfi5_rx_lane_checker #(
   parameter int DATA_WIDTH = 16,
   parameter int INCR       = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   sfi5_rx_lane_checker_if.slave lane
);

   typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

   localparam logic [DATA_WIDTH-1:0] INCR_W  = DATA_WIDTH'(INCR);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
   localparam logic [6:0]            RUN_MAX = 7'd127;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] prev_q, prev_d;
   logic [DATA_WIDTH-1:0] exp_q, exp_d;
   logic [6:0]            good_cnt_q, good_cnt_d;
   logic [6:0]            bad_cnt_q, bad_cnt_d;
   logic                  seeded_q, seeded_d;
   logic                  error_q, error_d;
   logic                  loss_q, loss_d;
   logic [CNT_WIDTH-1:0]  mism_q, mism_d;
   logic [CNT_WIDTH-1:0]  words_q, words_d;

   logic [6:0]            good_thr, bad_thr;
   logic [6:0]            good_inc, bad_inc;
   logic [DATA_WIDTH-1:0] prev_pred, exp_next;

   assign good_thr  = (lane.iv_GOOD2LOCK  == 7'd0) ? 7'd1 : lane.iv_GOOD2LOCK;
   assign bad_thr   = (lane.iv_BAD2UNLOCK == 7'd0) ? 7'd1 : lane.iv_BAD2UNLOCK;
   assign good_inc  = (good_cnt_q == RUN_MAX) ? RUN_MAX : good_cnt_q + 7'd1;
   assign bad_inc   = (bad_cnt_q  == RUN_MAX) ? RUN_MAX : bad_cnt_q + 7'd1;
   assign prev_pred = prev_q + INCR_W;
   assign exp_next  = exp_q + INCR_W;

   always_comb begin
      state_d    = state_q;
      prev_d     = prev_q;
      exp_d      = exp_q;
      good_cnt_d = good_cnt_q;
      bad_cnt_d  = bad_cnt_q;
      seeded_d   = seeded_q;
      error_d    = 1'b0;
      loss_d     = loss_q;
      mism_d     = mism_q;
      words_d    = words_q;

      if (lane.i_VALID) begin
         if (state_q == HUNT) begin
            prev_d = lane.iv_DATA;
            // The first word after reset/unlock has nothing to compare against.
            if (!seeded_q) begin
               seeded_d = 1'b1;
            end else begin
               good_cnt_d = (lane.iv_DATA == prev_pred) ? good_inc : 7'd0;
               if (good_cnt_d >= good_thr) begin
                  state_d   = LOCKED;
                  exp_d     = lane.iv_DATA + INCR_W;
                  bad_cnt_d = 7'd0;
               end
            end
         end else begin
            exp_d = exp_next;
            if (words_q != CNT_MAX) words_d = words_q + CNT_ONE;
            if (lane.iv_DATA == exp_q) begin
               bad_cnt_d = 7'd0;
            end else begin
               error_d   = 1'b1;
               bad_cnt_d = bad_inc;
               if (mism_q != CNT_MAX) mism_d = mism_q + CNT_ONE;
               // The word that breaks lock becomes the seed of the new hunt.
               if (bad_cnt_d >= bad_thr) begin
                  state_d    = HUNT;
                  loss_d     = 1'b1;
                  good_cnt_d = 7'd0;
                  prev_d     = lane.iv_DATA;
                  seeded_d   = 1'b1;
               end
            end
         end
      end

      if (lane.i_CLEAR) begin
         mism_d  = '0;
         words_d = '0;
         loss_d  = 1'b0;
      end
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q    <= HUNT;
         prev_q     <= '0;
         exp_q      <= '0;
         good_cnt_q <= 7'd0;
         bad_cnt_q  <= 7'd0;
         seeded_q   <= 1'b0;
         error_q    <= 1'b0;
         loss_q     <= 1'b0;
         mism_q     <= '0;
         words_q    <= '0;
      end else begin
         state_q    <= state_d;
         prev_q     <= prev_d;
         exp_q      <= exp_d;
         good_cnt_q <= good_cnt_d;
         bad_cnt_q  <= bad_cnt_d;
         seeded_q   <= seeded_d;
         error_q    <= error_d;
         loss_q     <= loss_d;
         mism_q     <= mism_d;
         words_q    <= words_d;
      end
   end

   assign lane.o_LOCKED         = (state_q == LOCKED);
   assign lane.o_ERROR          = error_q;
   assign lane.o_LOSS_HISTORY   = loss_q;
   assign lane.ov_MISMATCHES    = mism_q;
   assign lane.ov_WORDS_CHECKED = words_q;

endmodule

// File: tb/tb_sfi5_rx_lane_checker.sv
// Bench for sfi5_rx_lane_checker: two lanes (16-bit and 4-bit counters) share one
// stimulus stream and are compared every cycle against a behavioural lane model.
module tb_sfi5_rx_lane_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [15:0] data = '0;
   logic        clear = 1'b0;
   logic [6:0]  g2l = 7'd2;
   logic [6:0]  b2u = 7'd2;

   always #5 clk = ~clk;

   sfi5_rx_lane_checker_if #(.DATA_WIDTH(16), .CNT_WIDTH(16)) if_a ();
   sfi5_rx_lane_checker_if #(.DATA_WIDTH(16), .CNT_WIDTH(4))  if_b ();

   assign if_a.i_VALID = valid;       assign if_b.i_VALID = valid;
   assign if_a.iv_DATA = data;        assign if_b.iv_DATA = data;
   assign if_a.i_CLEAR = clear;       assign if_b.i_CLEAR = clear;
   assign if_a.iv_GOOD2LOCK = g2l;    assign if_b.iv_GOOD2LOCK = g2l;
   assign if_a.iv_BAD2UNLOCK = b2u;   assign if_b.iv_BAD2UNLOCK = b2u;

   sfi5_rx_lane_checker #(.DATA_WIDTH(16), .INCR(1), .CNT_WIDTH(16)) dut_a (
      .i_CLK(clk), .i_RST(rst), .lane(if_a.slave));
   sfi5_rx_lane_checker #(.DATA_WIDTH(16), .INCR(1), .CNT_WIDTH(4)) dut_b (
      .i_CLK(clk), .i_RST(rst), .lane(if_b.slave));

   int n_checks = 0;
   int n_pass   = 0;

   // Reference lane: unbounded event counts, clipped to the counter width on readout.
   int m_locked = 0, m_have_prev = 0, m_prev = 0, m_exp = 0;
   int m_good_run = 0, m_bad_run = 0;
   int m_mism = 0, m_words = 0, m_loss = 0, m_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   function automatic int clip(input int v, input int bits);
      int top;
      top = (1 << bits) - 1;
      return (v > top) ? top : v;
   endfunction

   function automatic int at_least_one(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic void model_edge(input int v, input int d, input int c, input int r,
                                      input int good_need, input int bad_need);
      if (r != 0) begin
         m_locked = 0; m_have_prev = 0; m_prev = 0; m_exp = 0;
         m_good_run = 0; m_bad_run = 0;
         m_mism = 0; m_words = 0; m_loss = 0; m_err = 0;
         return;
      end
      m_err = 0;
      if (v != 0) begin
         if (m_locked == 0) begin
            if (m_have_prev != 0) begin
               if (d == ((m_prev + 1) % 65536)) m_good_run = clip(m_good_run + 1, 7);
               else m_good_run = 0;
               if (m_good_run >= at_least_one(good_need)) begin
                  m_locked = 1;
                  m_exp = (d + 1) % 65536;
                  m_bad_run = 0;
               end
            end
            m_have_prev = 1;
            m_prev = d;
         end else begin
            m_words++;
            if (d == m_exp) begin
               m_bad_run = 0;
            end else begin
               m_err = 1;
               m_mism++;
               m_bad_run = clip(m_bad_run + 1, 7);
               if (m_bad_run >= at_least_one(bad_need)) begin
                  m_locked = 0;
                  m_loss = 1;
                  m_good_run = 0;
                  m_prev = d;
                  m_have_prev = 1;
               end
            end
            m_exp = (m_exp + 1) % 65536;
         end
      end
      if (c != 0) begin
         m_mism = 0; m_words = 0; m_loss = 0;
      end
   endfunction

   task automatic check_all();
      chk("a_locked", {31'd0, if_a.o_LOCKED}, m_locked);
      chk("a_error",  {31'd0, if_a.o_ERROR}, m_err);
      chk("a_loss",   {31'd0, if_a.o_LOSS_HISTORY}, m_loss);
      chk("a_mism",   {16'd0, if_a.ov_MISMATCHES}, clip(m_mism, 16));
      chk("a_words",  {16'd0, if_a.ov_WORDS_CHECKED}, clip(m_words, 16));
      chk("b_locked", {31'd0, if_b.o_LOCKED}, m_locked);
      chk("b_mism",   {28'd0, if_b.ov_MISMATCHES}, clip(m_mism, 4));
      chk("b_words",  {28'd0, if_b.ov_WORDS_CHECKED}, clip(m_words, 4));
   endtask

   task automatic step(input logic v, input logic [15:0] d, input logic c, input logic r);
      valid = v; data = d; clear = c; rst = r;
      @(posedge clk);
      model_edge(int'(v), int'(d), int'(c), int'(r), int'(g2l), int'(b2u));
      #1;
      check_all();
   endtask

   logic [15:0] seq;
   logic        rv;
   logic [15:0] rd;

   initial begin
      step(1'b0, 16'h0, 1'b0, 1'b1);
      step(1'b0, 16'h0, 1'b0, 1'b1);
      chk("reset_locked", {31'd0, if_a.o_LOCKED}, 32'd0);
      chk("reset_mism",   {16'd0, if_a.ov_MISMATCHES}, 32'd0);

      // Lock with GOOD2LOCK=2.
      g2l = 7'd2; b2u = 7'd2;
      step(1'b1, 16'h0010, 1'b0, 1'b0);
      step(1'b1, 16'h0011, 1'b0, 1'b0);
      chk("lock_not_yet", {31'd0, if_a.o_LOCKED}, 32'd0);
      step(1'b1, 16'h0012, 1'b0, 1'b0);
      chk("lock_after_12", {31'd0, if_a.o_LOCKED}, 32'd1);

      // Single corrupted word costs one mismatch.
      step(1'b1, 16'h0013, 1'b0, 1'b0);
      step(1'b1, 16'h9999, 1'b0, 1'b0);
      chk("single_err_pulse", {31'd0, if_a.o_ERROR}, 32'd1);
      step(1'b1, 16'h0015, 1'b0, 1'b0);
      chk("single_err_mism",  {16'd0, if_a.ov_MISMATCHES}, 32'd1);
      chk("single_err_words", {16'd0, if_a.ov_WORDS_CHECKED}, 32'd3);
      chk("single_err_lock",  {31'd0, if_a.o_LOCKED}, 32'd1);

      // Two consecutive bad words unlock, then relock keeps loss history.
      step(1'b0, 16'h0, 1'b1, 1'b0);
      step(1'b1, 16'h1234, 1'b0, 1'b0);
      step(1'b1, 16'h5678, 1'b0, 1'b0);
      chk("unlock_mism", {16'd0, if_a.ov_MISMATCHES}, 32'd2);
      chk("unlock_lock", {31'd0, if_a.o_LOCKED}, 32'd0);
      chk("unlock_loss", {31'd0, if_a.o_LOSS_HISTORY}, 32'd1);
      step(1'b1, 16'h0100, 1'b0, 1'b0);
      step(1'b1, 16'h0101, 1'b0, 1'b0);
      step(1'b1, 16'h0102, 1'b0, 1'b0);
      chk("relock_lock", {31'd0, if_a.o_LOCKED}, 32'd1);
      chk("relock_loss", {31'd0, if_a.o_LOSS_HISTORY}, 32'd1);

      // Wrap through 0xFFFF with valid gaps.
      step(1'b0, 16'h0, 1'b0, 1'b1);
      g2l = 7'd1;
      step(1'b1, 16'hFFFE, 1'b0, 1'b0);
      step(1'b1, 16'hFFFF, 1'b0, 1'b0);
      chk("wrap_lock", {31'd0, if_a.o_LOCKED}, 32'd1);
      step(1'b1, 16'h0000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 16'hDEAD, 1'b0, 1'b0);
      chk("gap_words_frozen", {16'd0, if_a.ov_WORDS_CHECKED}, 32'd1);
      step(1'b1, 16'h0001, 1'b0, 1'b0);
      chk("wrap_mism",  {16'd0, if_a.ov_MISMATCHES}, 32'd0);
      chk("wrap_words", {16'd0, if_a.ov_WORDS_CHECKED}, 32'd2);

      // Clear coinciding with a mismatch.
      step(1'b1, 16'h7777, 1'b1, 1'b0);
      chk("clr_err",  {31'd0, if_a.o_ERROR}, 32'd1);
      chk("clr_mism", {16'd0, if_a.ov_MISMATCHES}, 32'd0);
      chk("clr_lock", {31'd0, if_a.o_LOCKED}, 32'd1);

      // Saturation of the narrow lane, then reset mid-stream.
      b2u = 7'd127;
      for (int i = 0; i < 20; i++) step(1'b1, 16'hAAAA, 1'b0, 1'b0);
      chk("sat_b_mism", {28'd0, if_b.ov_MISMATCHES}, 32'hF);
      chk("sat_a_mism", {16'd0, if_a.ov_MISMATCHES}, 32'd20);
      step(1'b1, 16'hAAAA, 1'b0, 1'b1);
      chk("midrst_lock",  {31'd0, if_a.o_LOCKED}, 32'd0);
      chk("midrst_words", {16'd0, if_a.ov_WORDS_CHECKED}, 32'd0);
      chk("midrst_mism_b", {28'd0, if_b.ov_MISMATCHES}, 32'd0);

      // Random pattern stream with corruption, slips, gaps, clears and resets.
      g2l = 7'd2; b2u = 7'd2;
      seq = 16'($urandom);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) g2l = 7'($urandom_range(0, 5));
         if ($urandom_range(0, 49) == 0) b2u = 7'($urandom_range(0, 4));
         if ($urandom_range(0, 199) == 0) seq = 16'($urandom);
         rv = ($urandom_range(0, 9) < 8);
         rd = ($urandom_range(0, 19) == 0) ? 16'($urandom) : seq;
         if (rv) seq = seq + 16'd1;
         step(rv, rd, ($urandom_range(0, 99) == 0), ($urandom_range(0, 399) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
